// File: rtl/muldiv_unit.sv
// Multicycle MIPS-style HI/LO multiply/divide unit.
// A two-state FSM (idle/run) with a down-counter models the busy latency of
// mult/multu/div/divu; mthi/mtlo write HI/LO directly from idle. Results are
// computed combinationally from the operands latched at accept and are
// committed to HI/LO on the edge where the counter reaches zero.
module muldiv_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             move_to,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   // sel encodings
   localparam logic [2:0] SelHi = 3'b100;
   localparam logic [2:0] SelLo = 3'b101;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;     // sel[1:0] of the accepted op: bit1 = divide, bit0 = unsigned
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Request qualification
   logic start_ok;
   logic move_ok;

   // Datapath intermediates
   logic               op_signed;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic               a_neg;
   logic               b_neg;
   logic               b_zero;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;
   logic               res_we;

   // Accept only in idle; start wins over move_to and cancel suppresses both.
   always_comb begin
      start_ok = start && !cancel && (sel[2] == 1'b0);
      move_ok  = move_to && !start && !cancel && ((sel == SelHi) || (sel == SelLo));
   end

   // Multiply: sign- or zero-extend to 2*WIDTH so a plain product yields both halves.
   always_comb begin
      op_signed = ~op_q[0];
      ext_a     = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      ext_b     = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      product   = ext_a * ext_b;
   end

   // Divide on magnitudes, then restore signs. This also gives the
   // most-negative / -1 case (quotient = dividend, remainder 0) without overflow.
   always_comb begin
      a_neg  = op_signed && a_q[WIDTH-1];
      b_neg  = op_signed && b_q[WIDTH-1];
      b_zero = (b_q == '0);
      a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
      b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
      // Keep the divider well defined on divide-by-zero; the result is discarded.
      b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      quot   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
      rem    = a_neg ? (~r_mag + 1'b1) : r_mag;
   end

   // Select the result for the in-flight op; divide-by-zero leaves HI/LO alone.
   always_comb begin
      if (op_q[1]) begin
         res_hi = rem;
         res_lo = quot;
         res_we = !b_zero;
      end else begin
         res_hi = product[2*WIDTH-1:WIDTH];
         res_lo = product[WIDTH-1:0];
         res_we = 1'b1;
      end
   end

   // Next-state logic: accept, count down, commit or abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               a_d     = a;
               b_d     = b;
               op_d    = sel[1:0];
               cnt_d   = sel[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
               state_d = StRun;
            end else if (move_ok) begin
               if (sel[0]) begin
                  lo_d = a;
               end else begin
                  hi_d = a;
               end
            end
         end
         StRun: begin
            if (cancel) begin
               // Cancel beats completion, even on the final cycle.
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_d = StIdle;
                  if (res_we) begin
                     hi_d = res_hi;
                     lo_d = res_lo;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Outputs: register views plus the combinational HI/LO read port.
   always_comb begin
      busy = (state_q == StRun);
      hi   = hi_q;
      lo   = lo_q;
      if (sel == SelHi) begin
         rdata = hi_q;
      end else if (sel == SelLo) begin
         rdata = lo_q;
      end else begin
         rdata = '0;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and busy length are queued
// when an op is issued and compared when busy falls.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        move_to;
   logic [2:0]  sel;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic [31:0] rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] exp_q[$];
   int          cyc_q[$];

   muldiv_unit #(
      .WIDTH      (32),
      .MUL_CYCLES (5),
      .DIV_CYCLES (10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .move_to (move_to),
      .sel     (sel),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .busy    (busy),
      .rdata   (rdata),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: returns {hi, lo} after the op, given the current {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] s, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] cur);
      longint          sx, sy, sp, sq, sr;
      longint unsigned ux, uy, up, uq, ur;
      logic [63:0]     res;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'h0, x};
      uy = {32'h0, y};
      res = cur;
      case (s)
         3'b000: begin sp = sx * sy; res = sp; end
         3'b001: begin up = ux * uy; res = up; end
         3'b010: begin
            if (y != 0) begin
               sq = sx / sy;
               sr = sx % sy;
               res = {sr[31:0], sq[31:0]};
            end
         end
         3'b011: begin
            if (y != 0) begin
               uq = ux / uy;
               ur = ux % uy;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: res = cur;
      endcase
      return res;
   endfunction

   // Issue one op, optionally poke start/move_to while busy, then score it.
   task automatic do_op(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, input bit skip_sync);
      int n;
      if (!skip_sync) @(negedge clk);
      sel   = s;
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(model(s, x, y, {m_hi, m_lo}));
      cyc_q.push_back(s[1] ? 10 : 5);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      n     = 0;
      while (busy && n < 200) begin
         n++;
         move_to = 1'b0;
         start   = 1'b0;
         if (poke && n == 2) begin
            move_to = 1'b1;
            sel     = 3'b100;
            a       = 32'hDEADBEEF;
         end
         if (poke && n == 3) begin
            start = 1'b1;
            sel   = 3'b000;
            a     = 32'h7;
            b     = 32'h9;
         end
         @(negedge clk);
      end
      move_to = 1'b0;
      start   = 1'b0;
      check("busy_cycles", 64'(n), 64'(cyc_q.pop_front()));
      {m_hi, m_lo} = exp_q.pop_front();
      check("hilo", {hi, lo}, {m_hi, m_lo});
   endtask

   // Issue an op and raise cancel during busy cycle 'at'.
   task automatic do_cancel(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y,
                            input int at);
      int n;
      @(negedge clk);
      sel   = s;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      while (busy && n < 200) begin
         n++;
         if (n == at) cancel = 1'b1;
         @(negedge clk);
      end
      cancel = 1'b0;
      check("cancel_busy_len", 64'(n), 64'(at));
      check("cancel_hilo", {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      int n;
      reset   = 1'b0;
      start   = 1'b0;
      move_to = 1'b0;
      cancel  = 1'b0;
      sel     = 3'b100;
      a       = '0;
      b       = '0;
      m_hi    = '0;
      m_lo    = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_hilo", {hi, lo}, 64'h0);
      check("rst_rdata", 64'(rdata), 64'h0);
      reset = 1'b1;

      // Directed arithmetic, with fixed known answers alongside the model.
      do_op(3'b000, 32'hFFFFFFFE, 32'h3, 1'b0, 1'b0);
      check("mul_known", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
      do_op(3'b001, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0);
      check("mulu_known", {hi, lo}, 64'h00000001_FFFFFFFE);
      do_op(3'b010, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0);
      check("div_known", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      // Divide by zero, with move_to and start poked while busy.
      do_op(3'b011, 32'h7, 32'h0, 1'b1, 1'b0);
      check("divu_zero_known", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      check("div_ovf_known", {hi, lo}, 64'h00000000_80000000);
      do_op(3'b010, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b0);

      // Cancel mid-run and on the final run cycle.
      do_cancel(3'b010, 32'd1000, 32'd7, 4);
      do_cancel(3'b000, 32'd1000, 32'd7, 5);

      // start together with cancel never raises busy.
      @(negedge clk);
      sel    = 3'b010;
      a      = 32'd50;
      b      = 32'd3;
      start  = 1'b1;
      cancel = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("start_cancel_busy", 64'(busy), 64'(0));
         @(negedge clk);
      end

      // start with an unrelated sel is ignored.
      sel   = 3'b111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("bad_sel_busy", 64'(busy), 64'(0));
      check("bad_sel_hilo", {hi, lo}, {m_hi, m_lo});

      // mthi / mtlo and the read port.
      sel     = 3'b100;
      a       = 32'h12345678;
      move_to = 1'b1;
      @(negedge clk);
      m_hi    = 32'h12345678;
      sel     = 3'b101;
      a       = 32'h9ABCDEF0;
      @(negedge clk);
      m_lo    = 32'h9ABCDEF0;
      move_to = 1'b0;
      check("mv_busy", 64'(busy), 64'(0));
      sel = 3'b100;
      #1 check("rdata_hi", 64'(rdata), 64'h12345678);
      sel = 3'b101;
      #1 check("rdata_lo", 64'(rdata), 64'h9ABCDEF0);
      sel = 3'b110;
      #1 check("rdata_none", 64'(rdata), 64'h0);
      // move_to with cancel is suppressed.
      @(negedge clk);
      sel     = 3'b100;
      a       = 32'h55555555;
      move_to = 1'b1;
      cancel  = 1'b1;
      @(negedge clk);
      move_to = 1'b0;
      cancel  = 1'b0;
      #1 check("mv_cancel_hi", 64'(rdata), {32'h0, m_hi});

      // Random ops through the scoreboard.
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  rs;
         logic [31:0] ra, rb;
         rs = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? 32'h0 : $urandom;
         do_op(rs, ra, rb, 1'b0, 1'b0);
      end

      // Reset mid-divide clears outputs without a clock edge.
      do_op(3'b010, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0);
      sel   = 3'b010;
      a     = 32'hFFFFFFF9;
      b     = 32'h2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      while (busy && n < 3) begin
         n++;
         if (n < 3) @(negedge clk);
      end
      check("pre_rst_busy", 64'(busy), 64'(1));
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_hilo", {hi, lo}, 64'h0);
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      // Release reset and start on the very next edge.
      reset = 1'b1;
      do_op(3'b001, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
      check("post_rst_mulu", {hi, lo}, 64'h00000001_00000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 Parameter MUL_CYCLES, default 5, busy cycles for mult/multu (legal range >=1).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range >=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a mult/multu/div/divu as selected by sel.
REQ-007 move_to  input  1  request mthi/mtlo as selected by sel.
REQ-008 sel  input  3  000 MUL, 001 MULU, 010 DIV, 011 DIVU, 100 HI, 101 LO, 111 none.
REQ-009 a  input  WIDTH  rs operand.
REQ-010 b  input  WIDTH  rt operand.
REQ-011 cancel  input  1  pipeline exception or flush; suppresses or aborts the operation.
REQ-012 busy  output  1  operation in flight.
REQ-013 rdata  output  WIDTH  combinational read: HI when sel=100, LO when sel=101, else 0.
REQ-014 hi  output  WIDTH  registered HI.
REQ-015 lo  output  WIDTH  registered LO.

Function
REQ-016 The unit SHALL be an FSM with states IDLE and RUN plus a down-counter sized for max(MUL_CYCLES, DIV_CYCLES).
REQ-017 In IDLE, start=1 with sel in 000..011 and cancel=0 SHALL latch a, b and sel, load the counter with the per-op cycle count, and enter RUN at the next edge.
REQ-018 busy SHALL be 1 exactly in RUN, i.e. for MUL_CYCLES or DIV_CYCLES consecutive cycles beginning the cycle after start.
REQ-019 The counter SHALL decrement each RUN cycle; on the edge where it reaches 0, HI/LO SHALL take the result and the FSM SHALL return to IDLE, so the new HI/LO are visible as busy falls.
REQ-020 MUL SHALL produce the signed 2*WIDTH product and MULU the unsigned 2*WIDTH product, with HI = upper half and LO = lower half.
REQ-021 DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder carrying the dividend's sign; DIVU SHALL do the same unsigned.
REQ-022 DIV with a = most negative value and b = -1 SHALL give LO = a and HI = 0.
REQ-023 Divide by zero (DIV or DIVU) SHALL still occupy the full DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-024 In IDLE, move_to=1 with sel=100/101 and cancel=0 SHALL write a into HI/LO at the next edge, with no busy.
REQ-025 start or move_to while busy=1 SHALL be ignored; upstream stalls on busy.
REQ-026 start and move_to asserted together SHALL be treated as a protocol error: start takes priority and move_to is ignored.
REQ-027 start or move_to with an unrelated sel value SHALL be ignored.
REQ-028 cancel=1 in the same cycle as start or move_to SHALL suppress the request entirely.
REQ-029 cancel=1 during RUN SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and busy=0 from that edge.
REQ-030 If cancel=1 coincides with the final RUN cycle, cancel SHALL win and HI/LO SHALL stay unchanged.
REQ-031 rdata SHALL reflect the current HI/LO registers regardless of busy; no forwarding of the in-flight result.
REQ-032 Operands SHALL be sampled only at accept; later changes to a or b SHALL not affect the result.

Reset
REQ-033 Asserting reset at any time, including mid-RUN, SHALL immediately force state IDLE, counter 0, busy 0, hi 0, lo 0, and latched operands 0.
REQ-034 The first edge after reset deasserts SHALL accept start or move_to normally.

Verification
REQ-035 Reset, then start MUL with a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 Start MULU with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-037 Start DIV with a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7/0 -> hi/lo unchanged after 10 busy cycles.
REQ-038 Start DIV, assert cancel in busy cycle 4 -> busy=0 next cycle with hi/lo unchanged; also start+cancel in the same cycle -> busy never rises.
REQ-039 move_to sel=100 a=0x12345678, then sel=101 a=0x9ABCDEF0 -> rdata correct for sel=100/101; move_to during busy has no effect.
REQ-040 Drive reset low mid-DIV at cycle 3 -> busy, hi and lo read 0 immediately, without waiting for a clock edge.
